gtech_parity_chk4_rx: RTL and testbench
=======================================

// Module: gtech_parity_chk4_rx
// PURPOSE
//  Receive-side checker for nibble-parity protected data: the far end of a link whose
//  transmitter produces one XOR-of-4 parity bit per 4-bit lane.
//  Accepts words of LANES nibbles plus LANES parity bits over a valid/ready handshake.
//  Registers each word with a per-lane error mask, a sticky error flag and a saturating
//  error counter. Sits between the link deserialiser and the consuming datapath.
// PARAMETERS
//  LANES      4  number of 4-bit lanes; data width = 4*LANES
//  PARITY_ODD 0  0: even parity (lane^par == 0 is good); 1: odd parity (lane^par == 1 is good)
//  CNT_W      8  width of the error counter
// PORTS
//  CLK       in   1         rising-edge clock, single domain
//  RST       in   1         synchronous reset, active-high
//  IN_VALID  in   1         input word valid
//  IN_READY  out  1         checker can accept a word
//  IN_DATA   in   4*LANES   lane i = IN_DATA[4i+3:4i]
//  IN_PAR    in   LANES     parity bit of lane i
//  OUT_VALID out  1         registered word valid
//  OUT_READY in   1         downstream accepts word
//  OUT_DATA  out  4*LANES   registered copy of IN_DATA
//  OUT_ERR   out  LANES     bit i set = lane i parity mismatch
//  ERR_ANY   out  1         sticky: set by any accepted word with OUT_ERR != 0
//  ERR_CLR   in   1         clear ERR_ANY and the error counter (single-cycle pulse)
//  ERR_CNT   out  CNT_W     errored-word counter (macro-dependent, see CONFIGURATION)
// BEHAVIOUR
//  - Reset: one clock, synchronous, active-high. OUT_VALID=0, OUT_DATA=0, OUT_ERR=0,
//    ERR_ANY=0, ERR_CNT=0. IN_READY=1 from the first cycle after reset.
//  - Accept when IN_VALID & IN_READY. Deliver when OUT_VALID & OUT_READY.
//  - IN_READY = !OUT_VALID | OUT_READY. Single-entry output register, no bubbles.
//  - Latency: 1 cycle from accept to OUT_VALID. Full throughput of 1 word/cycle while
//    OUT_READY=1.
//  - Stall: while OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_ERR are held stable and
//    IN_READY=0.
//  - Error for lane i: (^IN_DATA[4i+3:4i]) ^ IN_PAR[i] != PARITY_ODD. This is computed
//    at accept and registered with the data.
//  - Errored words are still forwarded; dropping them is the consumer's decision.
//  - ERR_ANY and ERR_CNT update only on accepted words with a nonzero mask. A word
//    counts once regardless of how many lanes fail.
//  - ERR_CNT saturates at 2^CNT_W-1 and does not wrap.
//  - ERR_CLR together with an errored accept in the same cycle:
//    clear is applied first, then the increment, so ERR_CNT=1 and ERR_ANY=1.
//  - ERR_CLR during a stall affects only the flag and counter; data is held.
//  - RST asserted mid-operation discards the held word. OUT_VALID drops the cycle after
//    RST is sampled; there is no partial handshake.
//  - Control state: EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
//    EMPTY -> FULL on accept.
//    FULL -> EMPTY on deliver with no accept.
//    FULL -> FULL on deliver with accept, or on stall.
// CONFIGURATION
//  PARITY_ERR_CNT_EN defined: ERR_CNT counter is implemented as described above.
//  PARITY_ERR_CNT_EN undefined: no counter flops; ERR_CNT is tied to 0. The ERR_ANY sticky
//    flag and ERR_CLR still work.
// STRUCTURE
//  - Package gtech_parity_pkg holds:
//    LANE_W=4 constant;
//    function lane_par(4-bit) returning the XOR reduction;
//    localparam encodings for EMPTY and FULL.
//  - Sub-module gtech_parity_lane_chk: one lane, purely combinational, inputs nibble, par
//    and PARITY_ODD, output err. Instantiated LANES times in a generate loop.
//  - The top level owns the output register, handshake, sticky flag and counter.
// TESTING (LANES=2, PARITY_ODD=0, CNT_W=2 unless stated)
//  1. Clean words: DATA=8'hA5, PAR=2'b00, OUT_READY=1.
//     Expect the word 1 cycle later, OUT_ERR=2'b00, ERR_ANY=0, ERR_CNT=0.
//  2. Lane error: DATA=8'hA7, PAR=2'b00.
//     Expect OUT_ERR=2'b01, ERR_ANY=1, ERR_CNT=1. Then DATA=8'hA7, PAR=2'b01 gives
//     OUT_ERR=0 and ERR_CNT stays 1.
//  3. Backpressure: hold OUT_READY=0 for 3 cycles with OUT_VALID=1.
//     Expect IN_READY=0 and OUT_DATA/OUT_ERR stable. On OUT_READY=1 with IN_VALID=1, the
//     next word is accepted in the same cycle.
//  4. Saturation and clear: 5 errored words give ERR_CNT=3. Then ERR_CLR in the same cycle
//     as an errored accept gives ERR_CNT=1 and ERR_ANY=1.
//  5. Reset mid-stall: OUT_VALID=1, OUT_READY=0, RST pulsed for 1 cycle.
//     Expect all outputs 0 and IN_READY=1 next cycle, and the held word is never delivered.
//  6. Macro off: with PARITY_ERR_CNT_EN undefined, rerun scenario 2.
//     Expect ERR_ANY=1 and ERR_CNT=0 throughout.

Source files
------------

// File: rtl/gtech_parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gtech_parity_pkg
//  Description : Shared constants, helpers and control-state encodings for the
//                nibble-parity receive checker.
//                LANE_W    - width of one parity-protected lane (4 bits)
//                lane_par  - XOR reduction of one lane
//                EMPTY/FULL- output-register occupancy encodings
//  Revision    : 1.0 - initial release
// ============================================================================
package gtech_parity_pkg;

    localparam int LANE_W = 4;

    // Output register occupancy. The enum values reuse these encodings so the
    // state register width is explicit.
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    typedef enum logic [0:0] {
        ST_EMPTY = EMPTY,
        ST_FULL  = FULL
    } state_t;

    function automatic logic lane_par(input logic [LANE_W-1:0] nibble);
        return ^nibble;
    endfunction

endpackage : gtech_parity_pkg
`default_nettype wire

// File: rtl/gtech_parity_lane_chk.sv
`default_nettype none
// ============================================================================
//  Module      : gtech_parity_lane_chk
//  Description : Combinational parity check of a single 4-bit lane.
//  Ports       : nibble - lane data
//                par    - received parity bit for the lane
//                err    - 1 when the lane parity does not match PARITY_ODD
//  Parameters  : PARITY_ODD - 0 even parity, 1 odd parity
//  Revision    : 1.0 - initial release
// ============================================================================
module gtech_parity_lane_chk
    import gtech_parity_pkg::*;
#(
    parameter int PARITY_ODD = 0
) (
    input  logic [LANE_W-1:0] nibble,
    input  logic              par,
    output logic              err
);

    localparam logic C_ODD = (PARITY_ODD != 0);

    // Good lane: XOR of data and parity equals the selected parity sense.
    assign err = ((lane_par(nibble) ^ par) != C_ODD);

endmodule : gtech_parity_lane_chk
`default_nettype wire

// File: rtl/gtech_parity_chk4_rx.sv
`default_nettype none
// ============================================================================
//  Module      : gtech_parity_chk4_rx
//  Description : Receive-side nibble-parity checker. Accepts LANES nibbles plus
//                LANES parity bits over valid/ready, registers the word with a
//                per-lane error mask, keeps a sticky error flag and an optional
//                saturating errored-word counter. Errored words are forwarded.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                in_valid/in_ready  - input handshake
//                in_data/in_par     - lane i = in_data[4i+3:4i], parity in_par[i]
//                out_valid/out_ready- output handshake
//                out_data/out_err   - registered word and lane error mask
//                err_any            - sticky flag, set by any errored accept
//                err_clr            - pulse: clear err_any and err_cnt
//                err_cnt            - errored-word count (saturating)
//  Parameters  : LANES, PARITY_ODD, CNT_W
//  Macro       : PARITY_ERR_CNT_EN - when defined, err_cnt is a real counter;
//                otherwise no counter flops exist and err_cnt is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module gtech_parity_chk4_rx
    import gtech_parity_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int PARITY_ODD = 0,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANE_W*LANES-1:0] in_data,
    input  logic [LANES-1:0]      in_par,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANE_W*LANES-1:0] out_data,
    output logic [LANES-1:0]      out_err,
    output logic                  err_any,
    input  logic                  err_clr,
    output logic [CNT_W-1:0]      err_cnt
);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [LANE_W*LANES-1:0]   r_data;
    logic [LANES-1:0]          r_err;
    logic                      r_err_any;
    logic [LANES-1:0]          w_lane_err;
    logic                      w_accept;
    logic                      w_deliver;
    logic                      w_word_err;

    // ------------------------------------------------------------------
    // Per-lane parity checkers
    // ------------------------------------------------------------------
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gtech_parity_lane_chk #(
            .PARITY_ODD (PARITY_ODD)
        ) u_lane_chk (
            .nibble (in_data[LANE_W*i +: LANE_W]),
            .par    (in_par[i]),
            .err    (w_lane_err[i])
        );
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign out_valid  = (r_state == ST_FULL);
    // A full register can still take a new word in the cycle it is drained.
    assign in_ready   = !out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_deliver  = out_valid && out_ready;
    assign w_word_err = |w_lane_err;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_deliver && !w_accept) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register: loads only on accept, so it holds during a stall
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_err  <= '0;
        end else if (w_accept) begin
            r_data <= in_data;
            r_err  <= w_lane_err;
        end
    end

    assign out_data = r_data;
    assign out_err  = r_err;

    // ------------------------------------------------------------------
    // Sticky error flag: a same-cycle errored accept wins over the clear
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_any <= 1'b0;
        end else if (w_accept && w_word_err) begin
            r_err_any <= 1'b1;
        end else if (err_clr) begin
            r_err_any <= 1'b0;
        end
    end

    assign err_any = r_err_any;

    // ------------------------------------------------------------------
    // Errored-word counter
    // ------------------------------------------------------------------
`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_word_err) begin
            // Clear is applied before the increment, leaving a count of one.
            if (err_clr) begin
                r_err_cnt <= CNT_W'(1);
            end else if (r_err_cnt != {CNT_W{1'b1}}) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

endmodule : gtech_parity_chk4_rx
`default_nettype wire

// File: tb/tb_gtech_parity_chk4_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gtech_parity_chk4_rx
//  Description : Directed, table-driven bench for gtech_parity_chk4_rx with
//                LANES=2, PARITY_ODD=0, CNT_W=2. Expected counts follow the
//                PARITY_ERR_CNT_EN build setting (0 when the counter is absent).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gtech_parity_chk4_rx;

    localparam int LANES = 2;
    localparam int CNT_W = 2;
`ifdef PARITY_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [4*LANES-1:0] in_data = '0;
    logic [LANES-1:0]   in_par = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [4*LANES-1:0] out_data;
    logic [LANES-1:0]   out_err;
    logic               err_any;
    logic               err_clr = 1'b0;
    logic [CNT_W-1:0]   err_cnt;

    int total = 0;
    int bad   = 0;

    gtech_parity_chk4_rx #(
        .LANES      (LANES),
        .PARITY_ODD (0),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_par    (in_par),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_any   (err_any),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] par;
        logic [1:0] err;
        logic       any;
        int         cnt;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] ecnt(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic v, input logic [7:0] d,
                             input logic [1:0] e, input logic a, input logic [31:0] c);
        check({name, ".out_valid"}, 32'(out_valid), 32'(v));
        check({name, ".out_data"},  32'(out_data),  32'(d));
        check({name, ".out_err"},   32'(out_err),   32'(e));
        check({name, ".err_any"},   32'(err_any),   32'(a));
        check({name, ".err_cnt"},   32'(err_cnt),   c);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] p);
        in_valid = v;
        in_data  = d;
        in_par   = p;
    endtask

    initial begin
        // data, par, expected mask, expected sticky, expected count (counter build)
        vecs[0] = '{8'hA5, 2'b00, 2'b00, 1'b0, 0};
        vecs[1] = '{8'hA5, 2'b00, 2'b00, 1'b0, 0};
        vecs[2] = '{8'hA7, 2'b00, 2'b01, 1'b1, 1};
        vecs[3] = '{8'hA7, 2'b01, 2'b00, 1'b1, 1};
        vecs[4] = '{8'h3C, 2'b00, 2'b00, 1'b1, 1};
        vecs[5] = '{8'h3C, 2'b11, 2'b11, 1'b1, 2};
        vecs[6] = '{8'h81, 2'b00, 2'b11, 1'b1, 3};
        vecs[7] = '{8'h81, 2'b11, 2'b00, 1'b1, 3};
        vecs[8] = '{8'h80, 2'b01, 2'b11, 1'b1, 3};
        vecs[9] = '{8'hF0, 2'b10, 2'b10, 1'b1, 3};

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_out("reset", 1'b0, 8'h00, 2'b00, 1'b0, 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);

        // Streaming vectors at full throughput, one cycle latency
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].data, vecs[i].par);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), 1'b1, vecs[i].data, vecs[i].err,
                      vecs[i].any, ecnt(vecs[i].cnt));
            check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
        end
        drive(1'b0, 8'h00, 2'b00);
        @(negedge clk);
        check("drain.out_valid", 32'(out_valid), 32'd0);

        // Standalone clear
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr.err_any", 32'(err_any), 32'd0);
        check("clr.err_cnt", 32'(err_cnt), 32'd0);

        // Saturation: five errored words
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hA7, 2'b00);
            @(negedge clk);
        end
        check("sat.err_cnt", 32'(err_cnt), ecnt(3));
        check("sat.err_any", 32'(err_any), 32'd1);

        // Clear together with an errored accept: clear first, then count it
        err_clr = 1'b1;
        drive(1'b1, 8'hA7, 2'b00);
        @(negedge clk);
        check_out("clr_err_accept", 1'b1, 8'hA7, 2'b01, 1'b1, ecnt(1));
        // Clear together with a clean accept
        drive(1'b1, 8'hA5, 2'b00);
        @(negedge clk);
        err_clr = 1'b0;
        check_out("clr_clean_accept", 1'b1, 8'hA5, 2'b00, 1'b0, 32'd0);
        drive(1'b0, 8'h00, 2'b00);
        @(negedge clk);

        // Backpressure with a clear pulse during the stall
        drive(1'b1, 8'hA7, 2'b00);
        @(negedge clk);
        check_out("bp.load", 1'b1, 8'hA7, 2'b01, 1'b1, ecnt(1));
        out_ready = 1'b0;
        drive(1'b1, 8'h81, 2'b11);
        #1;
        check("bp.in_ready_low", 32'(in_ready), 32'd0);
        for (int j = 0; j < 3; j++) begin
            err_clr = (j == 0);
            @(negedge clk);
            err_clr = 1'b0;
            check_out($sformatf("bp.stall%0d", j), 1'b1, 8'hA7, 2'b01, 1'b0, 32'd0);
            check($sformatf("bp.stall%0d.in_ready", j), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_release", 32'(in_ready), 32'd1);
        @(negedge clk);
        check_out("bp.next_word", 1'b1, 8'h81, 2'b00, 1'b0, 32'd0);
        drive(1'b0, 8'h00, 2'b00);
        @(negedge clk);
        check("bp.drain", 32'(out_valid), 32'd0);

        // Reset in the middle of a stall: held word is discarded
        drive(1'b1, 8'h3C, 2'b11);
        @(negedge clk);
        drive(1'b0, 8'h00, 2'b00);
        out_ready = 1'b0;
        @(negedge clk);
        check_out("rst_stall.held", 1'b1, 8'h3C, 2'b11, 1'b1, ecnt(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_out("rst_stall.after", 1'b0, 8'h00, 2'b00, 1'b0, 32'd0);
        check("rst_stall.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("rst_stall.no_deliver%0d", j), 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gtech_parity_chk4_rx
`default_nettype wire
